// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared encodings for the memory port arbiter. The state
//                codes and owner codes are reused by the control unit and
//                by verification code that decodes the owner output.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Sequencer states of the shared memory port.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Owner codes, as driven on the owner output.
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_STACK = 2'd1;
    localparam logic [1:0] OWN_FETCH = 2'd2;
    localparam logic [1:0] OWN_DEBUG = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one synchronous memory port between stack traffic,
//                instruction fetch and a debug/loader port. Each access is
//                held on the port for WAIT_STATES+1 cycles, followed by one
//                response cycle carrying the owner's acknowledge and the
//                returned read data. Debug has top priority; stack beats
//                fetch unless fetch has lost STARVE_LIMIT arbitrations.
//
//  Ports       : clk, rst_n                 clock, async active-low reset
//                s_req/s_we/s_addr/s_wdata  stack request + payload
//                s_ack                      stack completion pulse
//                f_req/f_addr               fetch (read-only) request
//                f_ack                      fetch completion pulse
//                d_req/d_we/d_addr/d_wdata  debug request + payload
//                d_ack                      debug completion pulse
//                rdata                      read data, nonzero only in ack cycle
//                mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//                owner                      0 none, 1 stack, 2 fetch, 3 debug
//                busy                       access or response in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int WAIT_STATES  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_ack,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic              busy
);

    localparam logic [3:0] WAIT_LAST  = 4'(WAIT_STATES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Priority pick: debug first, then fetch/stack ordered by starvation.
    function automatic logic [1:0] pick_owner(
        input logic s_el,
        input logic f_el,
        input logic d_el,
        input logic fetch_first
    );
        logic [1:0] w;
        w = OWN_NONE;
        if (d_el) begin
            w = OWN_DEBUG;
        end else if (f_el && (fetch_first || !s_el)) begin
            w = OWN_FETCH;
        end else if (s_el) begin
            w = OWN_STACK;
        end
        return w;
    endfunction

    arb_state_e        state_q;
    logic [1:0]        owner_q;
    logic [3:0]        wait_q;
    logic [3:0]        starve_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              s_ack_q;
    logic              f_ack_q;
    logic              d_ack_q;

    logic              in_resp;
    logic              can_grant;
    logic              s_elig;
    logic              f_elig;
    logic              d_elig;
    logic [1:0]        win;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign in_resp   = (state_q == ST_RESP);
    assign can_grant = (state_q == ST_IDLE) || in_resp;

    // The requester being acknowledged still holds its req during the
    // response cycle, so it is masked out to avoid re-granting a stale request.
    assign s_elig = s_req && !(in_resp && (owner_q == OWN_STACK));
    assign f_elig = f_req && !(in_resp && (owner_q == OWN_FETCH));
    assign d_elig = d_req && !(in_resp && (owner_q == OWN_DEBUG));

    assign win   = pick_owner(s_elig, f_elig, d_elig, starve_q == STARVE_MAX);
    assign grant = can_grant && (win != OWN_NONE);

    // Payload of the winning requester; fetch is always a read.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        case (win)
            OWN_STACK: begin
                sel_we    = s_we;
                sel_addr  = s_addr;
                sel_wdata = s_wdata;
            end
            OWN_FETCH: begin
                sel_addr  = f_addr;
            end
            OWN_DEBUG: begin
                sel_we    = d_we;
                sel_addr  = d_addr;
                sel_wdata = d_wdata;
            end
            default: begin
                sel_we    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            wait_q      <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            s_ack_q     <= 1'b0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            s_ack_q <= 1'b0;
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;

            // Fetch starvation tracking: only meaningful while fetch waits.
            if (!f_req) begin
                starve_q <= '0;
            end else if (grant) begin
                if (win == OWN_FETCH) begin
                    starve_q <= '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_q <= starve_q + 4'd1;
                end
            end

            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (grant) begin
                        state_q     <= ST_ACCESS;
                        owner_q     <= win;
                        wait_q      <= '0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                    end else begin
                        state_q     <= ST_IDLE;
                        owner_q     <= OWN_NONE;
                    end
                end
                ST_ACCESS: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q  <= ST_RESP;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        s_ack_q  <= (owner_q == OWN_STACK);
                        f_ack_q  <= (owner_q == OWN_FETCH);
                        d_ack_q  <= (owner_q == OWN_DEBUG);
                    end else begin
                        wait_q   <= wait_q + 4'd1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    owner_q  <= OWN_NONE;
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ack     = s_ack_q;
    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != ST_IDLE);
    // Memory read data only becomes valid in the response cycle.
    assign rdata     = in_resp ? mem_rdata : '0;

endmodule
`default_nettype wire
